// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave fronting a 16 x 8-bit register bank. sclk, cs_n and mosi are
// oversampled in the clock domain; nothing is clocked by sclk.
module spi_reg_bank #(
  parameter logic [7:0] DEVICE_ID   = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  output logic [127:0] registers_packed,
  output logic         wr_strobe,
  output logic [3:0]   wr_addr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, armed_q;
  logic                   sclk_s, cs_s, mosi_s, rise_s;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, shifted_s;
  logic [3:0] ptr_q, ptr_d;
  logic       rw_q, rw_d, wr_en_s;
  logic [7:0] regs_q [1:15];
  logic       wr_strobe_q;
  logic [3:0] wr_addr_q;

  function automatic logic [7:0] rd_byte(input logic [127:0] bank, input logic [3:0] a);
    return bank[{a, 3'b000} +: 8];
  endfunction

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_prev_q;
  assign shifted_s = {rx_shift_q[6:0], mosi_s};

  // armed_q only sets once cs_n has been seen high, so a reset taken mid-frame
  // needs a fresh cs_n fall before another frame is accepted.
  assign miso_oe   = ~cs_s & armed_q;
  assign miso      = miso_oe & tx_shift_q[7];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

  // Input synchronizers and sclk edge history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_q | cs_s;
    end
  end

  // Packed view of the bank; address 0 is the fixed device ID.
  always_comb begin
    registers_packed = {120'h0, DEVICE_ID};
    for (int i = 1; i < 16; i++) begin
      registers_packed[8*i +: 8] = regs_q[i];
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    wr_en_s    = 1'b0;
    if (cs_s || !armed_q) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = CMD;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          tx_shift_d = 8'h00;
        end
        CMD: begin
          if (rise_s) begin
            rx_shift_d = shifted_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = DATA;
              rw_d       = shifted_s[7];
              ptr_d      = shifted_s[3:0];
              tx_shift_d = shifted_s[7] ? rd_byte(registers_packed, shifted_s[3:0]) : 8'h00;
            end else begin
              state_d = CMD;
            end
          end else begin
            state_d = CMD;
          end
        end
        DATA: begin
          if (rise_s) begin
            rx_shift_d = shifted_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd7) begin
              ptr_d      = ptr_q + 4'd1;
              tx_shift_d = rw_q ? rd_byte(registers_packed, ptr_q + 4'd1) : 8'h00;
              wr_en_s    = ~rw_q & (ptr_q != 4'd0);
            end else begin
              ptr_d = ptr_q;
            end
          end else begin
            state_d = DATA;
          end
        end
        default: begin
          state_d    = IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          tx_shift_d = 8'h00;
        end
      endcase
    end
  end

  // FSM state, register bank and write strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      ptr_q       <= 4'd0;
      rw_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      for (int i = 1; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      wr_strobe_q <= wr_en_s;
      if (wr_en_s) begin
        regs_q[ptr_q] <= shifted_s;
        wr_addr_q     <= ptr_q;
      end else begin
        wr_addr_q <= wr_addr_q;
      end
    end
  end

endmodule
